// File: rtl/rv_lsu_if.sv
// Request, response and data-memory signals of the load/store unit.
interface rv_lsu_if #(
  parameter int unsigned XLEN = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_op;
  logic [XLEN-1:0]   req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic [4:0]        req_rd;

  logic              rsp_valid;
  logic [XLEN-1:0]   rsp_rdata;
  logic [4:0]        rsp_rd;
  logic              rsp_fault;
  logic [3:0]        rsp_cause;
  logic [XLEN-1:0]   rsp_tval;

  logic [XLEN-1:0]   mem_d_addr;
  logic [XLEN-1:0]   mem_d_wdata;
  logic [XLEN/8-1:0] mem_d_wmask;
  logic              mem_d_wstrb;
  logic              mem_d_rstrb;
  logic [XLEN-1:0]   mem_d_rdata;
  logic              mem_d_rbusy;
  logic              mem_d_wbusy;

  // Environment side: core request source and data memory.
  modport master (
    output req_valid, req_store, req_op, req_addr, req_wdata, req_rd,
    output mem_d_rdata, mem_d_rbusy, mem_d_wbusy,
    input  req_ready, rsp_valid, rsp_rdata, rsp_rd, rsp_fault, rsp_cause, rsp_tval,
    input  mem_d_addr, mem_d_wdata, mem_d_wmask, mem_d_wstrb, mem_d_rstrb
  );

  // Load/store unit side.
  modport slave (
    input  req_valid, req_store, req_op, req_addr, req_wdata, req_rd,
    input  mem_d_rdata, mem_d_rbusy, mem_d_wbusy,
    output req_ready, rsp_valid, rsp_rdata, rsp_rd, rsp_fault, rsp_cause, rsp_tval,
    output mem_d_addr, mem_d_wdata, mem_d_wmask, mem_d_wstrb, mem_d_rstrb
  );
endinterface

// File: rtl/rv_lsu.sv
// rv_lsu: one-at-a-time load/store unit. Decodes and traps at accept, issues a single
// strobe, waits out the memory busy flag (with optional timeout) and returns one response.
module rv_lsu #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input logic     clk,
  input logic     rst,
  rv_lsu_if.slave bus
);
  localparam int unsigned NB   = XLEN / 8;
  localparam int unsigned OffW = $clog2(NB);
  localparam int unsigned LW   = $clog2(XLEN);
  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            store_q, store_d;
  logic [2:0]      op_q, op_d;
  logic [OffW-1:0] off_q, off_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] maddr_q, maddr_d;
  logic [XLEN-1:0] mwdata_q, mwdata_d;
  logic [NB-1:0]   mwmask_q, mwmask_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [4:0]      rsp_rd_q, rsp_rd_d;
  logic            fault_q, fault_d;
  logic [3:0]      cause_q, cause_d;
  logic [XLEN-1:0] tval_q, tval_d;

  logic [OffW-1:0] req_off;
  logic [3:0]      req_nb;
  logic            req_illegal, req_misalign;
  logic [XLEN-1:0] req_wrep;
  logic [NB-1:0]   req_mask;
  logic [XLEN-1:0] ld_shift, ld_ext;
  logic [LW-1:0]   ld_msb;
  logic            ld_sign;
  logic            busy;

  // Decode the incoming request: traps, byte enables and lane-replicated store data.
  always_comb begin
    req_off     = bus.req_addr[OffW-1:0];
    req_nb      = 4'd1 << bus.req_op[1:0];
    req_illegal = (bus.req_op == 3'b111) || (bus.req_store && bus.req_op[2]) ||
                  ((XLEN == 32) && (bus.req_op[1:0] == 2'b11 || bus.req_op == 3'b110));
    req_misalign = (req_off & OffW'(req_nb - 4'd1)) != '0;
    req_mask     = NB'(((32'd1 << req_nb) - 32'd1) << req_off);
    req_wrep     = '0;
    for (int i = 0; i < NB; i++) begin
      req_wrep[i*8 +: 8] = bus.req_wdata[{OffW'(i) & OffW'(req_nb - 4'd1), 3'b000} +: 8];
    end
  end

  // Extract the addressed bytes from the read word and extend them to XLEN.
  always_comb begin
    ld_shift = bus.mem_d_rdata >> {off_q, 3'b000};
    // Truncation to LW bits clamps an (illegal) oversized width to XLEN-1.
    ld_msb   = LW'((32'd8 << op_q[1:0]) - 32'd1);
    ld_sign  = ~op_q[2] & ld_shift[ld_msb];
    ld_ext   = ld_shift;
    for (int i = 0; i < XLEN; i++) begin
      if (i > int'(ld_msb)) ld_ext[i] = ld_sign;
    end
  end

  // Next-state, transaction capture and response formation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    store_d  = store_q;
    op_d     = op_q;
    off_d    = off_q;
    rd_d     = rd_q;
    addr_d   = addr_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    mwmask_d = mwmask_q;
    rdata_d  = rdata_q;
    rsp_rd_d = rsp_rd_q;
    fault_d  = fault_q;
    cause_d  = cause_q;
    tval_d   = tval_q;
    busy     = store_q ? bus.mem_d_wbusy : bus.mem_d_rbusy;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          store_d  = bus.req_store;
          op_d     = bus.req_op;
          off_d    = req_off;
          rd_d     = bus.req_rd;
          addr_d   = bus.req_addr;
          cnt_d    = '0;
          rdata_d  = '0;
          rsp_rd_d = '0;
          if (req_illegal) begin
            fault_d = 1'b1;
            cause_d = 4'd2;
            tval_d  = '0;
            state_d = StResp;
          end else if (req_misalign) begin
            fault_d = 1'b1;
            cause_d = bus.req_store ? 4'd6 : 4'd4;
            tval_d  = bus.req_addr;
            state_d = StResp;
          end else begin
            maddr_d  = {bus.req_addr[XLEN-1:OffW], OffW'(0)};
            mwdata_d = req_wrep;
            mwmask_d = req_mask;
            state_d  = StIssue;
          end
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (!busy) begin
          fault_d  = 1'b0;
          cause_d  = '0;
          tval_d   = '0;
          rdata_d  = store_q ? '0 : ld_ext;
          rsp_rd_d = store_q ? '0 : rd_q;
          state_d  = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if ((TIMEOUT != 0) && (32'(cnt_q) + 32'd1 == TIMEOUT)) begin
            fault_d = 1'b1;
            cause_d = store_q ? 4'd7 : 4'd5;
            tval_d  = addr_q;
            state_d = StResp;
          end
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      store_q  <= 1'b0;
      op_q     <= '0;
      off_q    <= '0;
      rd_q     <= '0;
      addr_q   <= '0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      mwmask_q <= '0;
      rdata_q  <= '0;
      rsp_rd_q <= '0;
      fault_q  <= 1'b0;
      cause_q  <= '0;
      tval_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      store_q  <= store_d;
      op_q     <= op_d;
      off_q    <= off_d;
      rd_q     <= rd_d;
      addr_q   <= addr_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      mwmask_q <= mwmask_d;
      rdata_q  <= rdata_d;
      rsp_rd_q <= rsp_rd_d;
      fault_q  <= fault_d;
      cause_q  <= cause_d;
      tval_q   <= tval_d;
    end
  end

  // Drive the bus from state and held registers.
  always_comb begin
    bus.req_ready   = (state_q == StIdle);
    bus.rsp_valid   = (state_q == StResp);
    bus.rsp_rdata   = rdata_q;
    bus.rsp_rd      = rsp_rd_q;
    bus.rsp_fault   = fault_q;
    bus.rsp_cause   = cause_q;
    bus.rsp_tval    = tval_q;
    bus.mem_d_addr  = maddr_q;
    bus.mem_d_wdata = mwdata_q;
    bus.mem_d_wmask = mwmask_q;
    bus.mem_d_rstrb = (state_q == StIssue) && !store_q;
    bus.mem_d_wstrb = (state_q == StIssue) && store_q;
  end
endmodule

// File: tb/tb_rv_lsu.sv
// Bench for rv_lsu: an RV32 and an RV64 instance (TIMEOUT=4) behind one shared stimulus
// bus, directed scenarios plus randomized transactions against an arithmetic model.
module tb_rv_lsu;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        sel64 = 1'b0;
  logic        t_valid = 1'b0, t_store = 1'b0, t_rbusy = 1'b0, t_wbusy = 1'b0;
  logic [2:0]  t_op = '0;
  logic [63:0] t_addr = '0, t_wdata = '0, t_rdata = '0;
  logic [4:0]  t_rd = '0;

  rv_lsu_if #(.XLEN(32)) if32 ();
  rv_lsu_if #(.XLEN(64)) if64 ();

  assign if32.req_valid = t_valid & ~sel64;
  assign if64.req_valid = t_valid & sel64;
  assign if32.req_store = t_store;
  assign if64.req_store = t_store;
  assign if32.req_op = t_op;
  assign if64.req_op = t_op;
  assign if32.req_addr = t_addr[31:0];
  assign if64.req_addr = t_addr;
  assign if32.req_wdata = t_wdata[31:0];
  assign if64.req_wdata = t_wdata;
  assign if32.req_rd = t_rd;
  assign if64.req_rd = t_rd;
  assign if32.mem_d_rdata = t_rdata[31:0];
  assign if64.mem_d_rdata = t_rdata;
  assign if32.mem_d_rbusy = t_rbusy;
  assign if64.mem_d_rbusy = t_rbusy;
  assign if32.mem_d_wbusy = t_wbusy;
  assign if64.mem_d_wbusy = t_wbusy;

  rv_lsu #(.XLEN(32), .TIMEOUT(TMO)) dut32 (.clk(clk), .rst(rst), .bus(if32.slave));
  rv_lsu #(.XLEN(64), .TIMEOUT(TMO)) dut64 (.clk(clk), .rst(rst), .bus(if64.slave));

  // Observed view of the selected instance, zero-extended to 64 bits.
  logic        o_ready, o_rsp_valid, o_fault, o_rstrb, o_wstrb;
  logic [3:0]  o_cause;
  logic [4:0]  o_rd;
  logic [7:0]  o_wmask;
  logic [63:0] o_rdata, o_tval, o_maddr, o_wdata;
  assign o_ready     = sel64 ? if64.req_ready   : if32.req_ready;
  assign o_rsp_valid = sel64 ? if64.rsp_valid   : if32.rsp_valid;
  assign o_fault     = sel64 ? if64.rsp_fault   : if32.rsp_fault;
  assign o_rstrb     = sel64 ? if64.mem_d_rstrb : if32.mem_d_rstrb;
  assign o_wstrb     = sel64 ? if64.mem_d_wstrb : if32.mem_d_wstrb;
  assign o_cause     = sel64 ? if64.rsp_cause   : if32.rsp_cause;
  assign o_rd        = sel64 ? if64.rsp_rd      : if32.rsp_rd;
  assign o_wmask     = sel64 ? if64.mem_d_wmask : {4'b0, if32.mem_d_wmask};
  assign o_rdata     = sel64 ? if64.rsp_rdata   : {32'b0, if32.rsp_rdata};
  assign o_tval      = sel64 ? if64.rsp_tval    : {32'b0, if32.rsp_tval};
  assign o_maddr     = sel64 ? if64.mem_d_addr  : {32'b0, if32.mem_d_addr};
  assign o_wdata     = sel64 ? if64.mem_d_wdata : {32'b0, if32.mem_d_wdata};

  int n_checks = 0;
  int n_pass = 0;

  // Results of the last run_txn.
  int          obs_nr, obs_nw, obs_strb_k, obs_rsp_k;
  logic        obs_ready0, obs_stable, obs_after_ok, obs_fault;
  logic [3:0]  obs_cause;
  logic [4:0]  obs_rd;
  logic [7:0]  obs_wmask;
  logic [63:0] obs_rdata, obs_tval, obs_maddr, obs_wdata;

  // Model outputs.
  int          exp_k, exp_nstrb;
  logic        exp_fault;
  logic [3:0]  exp_cause;
  logic [4:0]  exp_rd;
  logic [7:0]  exp_wmask;
  logic [63:0] exp_rdata, exp_tval, exp_maddr, exp_wdata;

  function automatic logic [63:0] bmask(input int nbytes);
    return (nbytes >= 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nbytes)) - 64'd1);
  endfunction

  // Reference behaviour from the architectural rules: traps, lanes, extension, latency.
  task automatic model(input bit s64, input bit st, input logic [2:0] op,
                       input logic [63:0] addr, input logic [63:0] wd, input logic [4:0] rd,
                       input logic [63:0] mw, input int busy);
    int xl = s64 ? 64 : 32;
    int nb = xl / 8;
    int sz = 1 << op[1:0];
    logic [63:0] xm = bmask(nb);
    logic [63:0] a = addr & xm;
    int off = int'(a % 64'(nb));
    logic [63:0] pat, v;
    exp_fault = 0; exp_cause = 0; exp_tval = 0; exp_rdata = 0; exp_rd = 0;
    exp_k = 3 + busy; exp_nstrb = 1; exp_maddr = 0; exp_wmask = 0; exp_wdata = 0;
    if (op == 3'd7 || (!s64 && (op == 3'd3 || op == 3'd6)) || (st && op[2])) begin
      exp_fault = 1; exp_cause = 4'd2; exp_k = 1; exp_nstrb = 0;
    end else if (off % sz != 0) begin
      exp_fault = 1; exp_cause = st ? 4'd6 : 4'd4; exp_tval = a; exp_k = 1; exp_nstrb = 0;
    end else begin
      exp_maddr = a - 64'(off);
      exp_wmask = 8'(((1 << sz) - 1) << off);
      pat = wd & bmask(sz);
      for (int r = 0; r < nb / sz; r++) exp_wdata = exp_wdata | (pat << (8 * sz * r));
      if (busy >= TMO) begin
        exp_fault = 1; exp_cause = st ? 4'd7 : 4'd5; exp_tval = a; exp_k = 2 + TMO;
      end else if (!st) begin
        v = ((mw & xm) >> (8 * off)) & bmask(sz);
        if (!op[2] && v[8*sz-1]) v = v | ~bmask(sz);
        exp_rdata = v & xm;
        exp_rd = rd;
      end
    end
  endtask

  // Present one request, act as the memory (busy for 'busy' WAIT cycles, junk data while
  // busy), and record everything seen up to one cycle after the response.
  task automatic run_txn(input bit s64, input bit st, input logic [2:0] op,
                         input logic [63:0] addr, input logic [63:0] wd,
                         input logic [4:0] rd, input logic [63:0] mw, input int busy);
    int s = -1;
    bit bn;
    sel64 = s64;
    obs_nr = 0; obs_nw = 0; obs_strb_k = -1; obs_rsp_k = -1; obs_stable = 1;
    obs_maddr = 0; obs_wmask = 0; obs_wdata = 0;
    @(negedge clk);
    obs_ready0 = o_ready;
    t_valid = 1; t_store = st; t_op = op; t_addr = addr; t_wdata = wd; t_rd = rd;
    t_rbusy = 0; t_wbusy = 0; t_rdata = mw;
    @(negedge clk);
    t_valid = 0; t_store = 1'($urandom); t_op = 3'($urandom); t_rd = 5'($urandom);
    t_addr = {$urandom, $urandom}; t_wdata = {$urandom, $urandom};
    for (int k = 1; k <= 40 && obs_rsp_k < 0; k++) begin
      if (o_rstrb) obs_nr++;
      if (o_wstrb) obs_nw++;
      if (o_rsp_valid) begin
        obs_rsp_k = k; obs_fault = o_fault; obs_cause = o_cause; obs_tval = o_tval;
        obs_rdata = o_rdata; obs_rd = o_rd;
      end else if ((o_rstrb || o_wstrb) && s < 0) begin
        s = k; obs_strb_k = k; obs_maddr = o_maddr; obs_wmask = o_wmask; obs_wdata = o_wdata;
      end else if (s >= 0 && (o_maddr !== obs_maddr || o_wmask !== obs_wmask ||
                              o_wdata !== obs_wdata)) begin
        obs_stable = 0;
      end
      bn = (s >= 0) && (k > s) && (k <= s + busy);
      if (st) begin t_wbusy = bn; t_rbusy = 1'($urandom); end
      else begin t_rbusy = bn; t_wbusy = 1'($urandom); end
      t_rdata = bn ? {$urandom, $urandom} : mw;
      if (obs_rsp_k < 0) @(negedge clk);
    end
    @(negedge clk);
    obs_after_ok = (o_rsp_valid === 1'b0) && (o_ready === 1'b1) && !o_rstrb && !o_wstrb;
    t_rbusy = 0; t_wbusy = 0;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      sel64 = d[0];
      #1;
      n_checks++;
      if (o_ready !== 1'b1 || o_rsp_valid !== 1'b0 || o_rstrb !== 1'b0 || o_wstrb !== 1'b0)
        $display("FAIL reset_ctl dut%0d: ready=%b rsp_valid=%b rstrb=%b wstrb=%b, want 1 0 0 0",
                 d, o_ready, o_rsp_valid, o_rstrb, o_wstrb);
      else n_pass++;
      n_checks++;
      if (o_fault !== 1'b0 || o_cause !== 4'd0 || o_tval !== 64'd0 || o_rdata !== 64'd0 ||
          o_rd !== 5'd0)
        $display("FAIL reset_rsp dut%0d: fault=%b cause=%0d tval=%h rdata=%h rd=%0d, want 0",
                 d, o_fault, o_cause, o_tval, o_rdata, o_rd);
      else n_pass++;
      n_checks++;
      if (o_maddr !== 64'd0 || o_wmask !== 8'd0 || o_wdata !== 64'd0)
        $display("FAIL reset_mem dut%0d: addr=%h wmask=%b wdata=%h, want 0",
                 d, o_maddr, o_wmask, o_wdata);
      else n_pass++;
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_lw_basic();
    run_txn(0, 0, 3'b010, 64'h100, 64'h0, 5'd7, 64'h8000_00FF, 0);
    n_checks++;
    if (obs_nr !== 1 || obs_nw !== 0 || obs_strb_k !== 1)
      $display("FAIL lw_strobe: rstrb=%0d wstrb=%0d at cycle %0d, want 1 0 at 1",
               obs_nr, obs_nw, obs_strb_k);
    else n_pass++;
    n_checks++;
    if (obs_rsp_k !== 3 || obs_fault !== 1'b0 || obs_rdata !== 64'h8000_00FF || obs_rd !== 5'd7)
      $display("FAIL lw_rsp: k=%0d fault=%b rdata=%h rd=%0d, want 3 0 800000ff 7",
               obs_rsp_k, obs_fault, obs_rdata, obs_rd);
    else n_pass++;
  endtask

  task automatic test_lb_lbu();
    run_txn(0, 0, 3'b000, 64'h103, 64'h0, 5'd3, 64'h8012_3456, 0);
    n_checks++;
    if (obs_rdata !== 64'hFFFF_FF80 || obs_fault !== 1'b0)
      $display("FAIL lb_sext: rdata=%h fault=%b, want ffffff80 0", obs_rdata, obs_fault);
    else n_pass++;
    run_txn(0, 0, 3'b100, 64'h103, 64'h0, 5'd3, 64'h8012_3456, 0);
    n_checks++;
    if (obs_rdata !== 64'h0000_0080 || obs_fault !== 1'b0)
      $display("FAIL lbu_zext: rdata=%h fault=%b, want 00000080 0", obs_rdata, obs_fault);
    else n_pass++;
  endtask

  task automatic test_sh();
    run_txn(0, 1, 3'b001, 64'h202, 64'h1234_ABCD, 5'd9, 64'h0, 0);
    n_checks++;
    if (obs_maddr !== 64'h200 || obs_wmask !== 8'b1100 || obs_wdata !== 64'hABCD_ABCD)
      $display("FAIL sh_lanes: addr=%h wmask=%b wdata=%h, want 200 1100 abcdabcd",
               obs_maddr, obs_wmask, obs_wdata);
    else n_pass++;
    n_checks++;
    if (obs_nw !== 1 || obs_nr !== 0 || obs_fault !== 1'b0 || obs_rd !== 5'd0 ||
        obs_rdata !== 64'd0)
      $display("FAIL sh_rsp: wstrb=%0d rstrb=%0d fault=%b rd=%0d rdata=%h, want 1 0 0 0 0",
               obs_nw, obs_nr, obs_fault, obs_rd, obs_rdata);
    else n_pass++;
  endtask

  task automatic test_traps();
    run_txn(0, 0, 3'b010, 64'h101, 64'h0, 5'd4, 64'h0, 0);
    n_checks++;
    if (obs_nr !== 0 || obs_fault !== 1'b1 || obs_cause !== 4'd4 || obs_tval !== 64'h101 ||
        obs_rsp_k !== 1)
      $display("FAIL lw_misalign: rstrb=%0d fault=%b cause=%0d tval=%h k=%0d, want 0 1 4 101 1",
               obs_nr, obs_fault, obs_cause, obs_tval, obs_rsp_k);
    else n_pass++;
    // Misaligned as well as illegal: illegal wins.
    run_txn(0, 1, 3'b011, 64'h105, 64'h0, 5'd4, 64'h0, 0);
    n_checks++;
    if (obs_nw !== 0 || obs_fault !== 1'b1 || obs_cause !== 4'd2 || obs_tval !== 64'h0)
      $display("FAIL sd_illegal32: wstrb=%0d fault=%b cause=%0d tval=%h, want 0 1 2 0",
               obs_nw, obs_fault, obs_cause, obs_tval);
    else n_pass++;
  endtask

  task automatic test_timeout();
    run_txn(0, 0, 3'b010, 64'h300, 64'h0, 5'd5, 64'h1111_2222, 10);
    n_checks++;
    if (obs_fault !== 1'b1 || obs_cause !== 4'd5 || obs_tval !== 64'h300 || obs_rsp_k !== 6 ||
        obs_rdata !== 64'd0 || obs_rd !== 5'd0)
      $display("FAIL lw_timeout: fault=%b cause=%0d tval=%h k=%0d rdata=%h rd=%0d, want 1 5 300 6 0 0",
               obs_fault, obs_cause, obs_tval, obs_rsp_k, obs_rdata, obs_rd);
    else n_pass++;
    run_txn(0, 0, 3'b010, 64'h300, 64'h0, 5'd5, 64'hCAFE_F00D, 3);
    n_checks++;
    if (obs_fault !== 1'b0 || obs_rdata !== 64'hCAFE_F00D || obs_rsp_k !== 6 || !obs_stable)
      $display("FAIL lw_busy3: fault=%b rdata=%h k=%0d stable=%b, want 0 cafef00d 6 1",
               obs_fault, obs_rdata, obs_rsp_k, obs_stable);
    else n_pass++;
  endtask

  task automatic test_rv64_lwu();
    run_txn(1, 0, 3'b110, 64'h0C, 64'h0, 5'd11, 64'hDEAD_BEEF_0000_0001, 0);
    n_checks++;
    if (obs_rdata !== 64'h0000_0000_DEAD_BEEF || obs_fault !== 1'b0 || obs_maddr !== 64'h08 ||
        obs_rd !== 5'd11)
      $display("FAIL lwu64: rdata=%h fault=%b addr=%h rd=%0d, want 00000000deadbeef 0 8 11",
               obs_rdata, obs_fault, obs_maddr, obs_rd);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    sel64 = 1;
    @(negedge clk);
    t_valid = 1; t_store = 0; t_op = 3'b011; t_addr = 64'h40; t_rd = 5'd2; t_rbusy = 1;
    @(negedge clk);
    t_valid = 0;
    @(negedge clk);
    n_checks++;
    if (o_ready !== 1'b0) $display("FAIL mid_busy_ready: ready=%b, want 0", o_ready);
    else n_pass++;
    rst = 1;
    t_rbusy = 0;
    #1;
    n_checks++;
    if (o_ready !== 1'b1 || o_rsp_valid !== 1'b0)
      $display("FAIL mid_async_rst: ready=%b rsp_valid=%b, want 1 0", o_ready, o_rsp_valid);
    else n_pass++;
    @(negedge clk);
    rst = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (o_rsp_valid || !o_ready) seen = 1;
    end
    n_checks++;
    if (seen) $display("FAIL mid_no_rsp: response or busy after abort=%b, want 0", seen);
    else n_pass++;
    run_txn(1, 0, 3'b011, 64'h48, 64'h0, 5'd6, 64'h1122_3344_5566_7788, 0);
    n_checks++;
    if (obs_rdata !== 64'h1122_3344_5566_7788 || obs_rsp_k !== 3 || obs_fault !== 1'b0)
      $display("FAIL ld64_after_rst: rdata=%h k=%0d fault=%b, want 1122334455667788 3 0",
               obs_rdata, obs_rsp_k, obs_fault);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [8:0]  vpat = '0;
    logic [31:0] r3 = '0, r7 = '0;
    sel64 = 0;
    t_rbusy = 0; t_wbusy = 0; t_rdata = 64'h8001_7FFE;
    @(negedge clk);
    t_valid = 1; t_store = 0; t_op = 3'b001; t_addr = 64'h2; t_rd = 5'd1;
    @(negedge clk);
    // Second request held until the unit is idle again.
    t_op = 3'b101; t_addr = 64'h0; t_rd = 5'd2;
    for (int k = 1; k <= 8; k++) begin
      vpat[k] = o_rsp_valid;
      if (k == 3) r3 = o_rdata[31:0];
      if (k == 7) r7 = o_rdata[31:0];
      if (k == 4) begin
        @(posedge clk);
        #1 t_valid = 0;
        @(negedge clk);
      end else begin
        @(negedge clk);
      end
    end
    n_checks++;
    if (vpat !== 9'b0_1000_1000)
      $display("FAIL b2b_pulses: rsp_valid pattern=%b, want 010001000", vpat);
    else n_pass++;
    n_checks++;
    if (r3 !== 32'hFFFF_8001 || r7 !== 32'h0000_7FFE)
      $display("FAIL b2b_data: first=%h second=%h, want ffff8001 00007ffe", r3, r7);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      bit s64;
      bit st;
      logic [2:0] op;
      logic [63:0] addr, wd, mw;
      logic [4:0] rd;
      int busy;
      s64 = (n >= 45);
      st = 1'($urandom);
      op = 3'($urandom);
      addr = s64 ? {$urandom, $urandom} : {32'h0, $urandom};
      if ($urandom_range(0, 1) == 1) addr = addr & ~((64'd1 << op[1:0]) - 64'd1);
      wd = {$urandom, $urandom};
      mw = {$urandom, $urandom};
      rd = 5'($urandom);
      busy = $urandom_range(0, 5);
      model(s64, st, op, addr, wd, rd, mw, busy);
      run_txn(s64, st, op, addr, wd, rd, mw, busy);
      n_checks++;
      if (obs_rsp_k !== exp_k || obs_ready0 !== 1'b1 || !obs_after_ok)
        $display("FAIL rand_timing #%0d: k=%0d ready0=%b after=%b, want %0d 1 1",
                 n, obs_rsp_k, obs_ready0, obs_after_ok, exp_k);
      else n_pass++;
      n_checks++;
      if (obs_fault !== exp_fault || obs_cause !== exp_cause || obs_tval !== exp_tval)
        $display("FAIL rand_trap #%0d op=%0d st=%b: fault=%b cause=%0d tval=%h, want %b %0d %h",
                 n, op, st, obs_fault, obs_cause, obs_tval, exp_fault, exp_cause, exp_tval);
      else n_pass++;
      n_checks++;
      if (obs_rdata !== exp_rdata || obs_rd !== exp_rd)
        $display("FAIL rand_load #%0d op=%0d: rdata=%h rd=%0d, want %h %0d",
                 n, op, obs_rdata, obs_rd, exp_rdata, exp_rd);
      else n_pass++;
      n_checks++;
      if (obs_nr !== ((exp_nstrb != 0 && !st) ? 1 : 0) ||
          obs_nw !== ((exp_nstrb != 0 && st) ? 1 : 0))
        $display("FAIL rand_strobe #%0d: rstrb=%0d wstrb=%0d, want %0d for store=%b",
                 n, obs_nr, obs_nw, exp_nstrb, st);
      else n_pass++;
      if (exp_nstrb != 0) begin
        n_checks++;
        if (obs_maddr !== exp_maddr || obs_wmask !== exp_wmask || obs_wdata !== exp_wdata ||
            !obs_stable)
          $display("FAIL rand_mem #%0d: addr=%h wmask=%b wdata=%h stable=%b, want %h %b %h 1",
                   n, obs_maddr, obs_wmask, obs_wdata, obs_stable,
                   exp_maddr, exp_wmask, exp_wdata);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw_basic();
    test_lb_lbu();
    test_sh();
    test_traps();
    test_timeout();
    test_rv64_lwu();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
